// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder stage per clock, LSB first.
// Optional registered signed-overflow output `ovf` when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb, sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_c;
  logic             last, take;

  assign fa_s = sa[0] ^ sb[0] ^ carry;
  assign fa_c = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign last = (cnt == CW'(WIDTH - 1));
  assign take = (state == IDLE) && start;

  // result bits enter at the MSB so the LSB ends up at bit 0
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_sh = fa_s;
    end else begin : g_wn
      assign sum_sh = {fa_s, sum[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        sa    <= a;
        sb    <= b;
        carry <= cin;
        cnt   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (state == ADD) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        carry <= fa_c;
        cnt   <= cnt + CW'(1);
        sum   <= sum_sh;
        if (last) cout <= fa_c;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // carry still holds the carry into the MSB during the last ADD cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (take) begin
      ovf <= 1'b0;
    end else if (state == ADD && last) begin
      ovf <= carry ^ fa_c;
    end
  end
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and sum width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being added.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-013 In IDLE with start=1 at a rising edge: SHALL load a, b into shift registers, load carry flop with cin, clear bit counter, clear sum register, go to ADD.
REQ-014 In ADD: each cycle SHALL add one bit pair LSB-first through a single full-adder stage (sum bit = a0^b0^carry, carry' = majority), shift the sum bit into the sum register from the MSB side, shift operands right, and increment the counter.
REQ-015 After exactly WIDTH ADD cycles SHALL go to DONE, with sum holding the full result and cout the final carry.
REQ-016 In DONE: done SHALL be 1 for exactly one cycle; next state is IDLE unconditionally.
REQ-017 Latency: done SHALL be high in the cycle WIDTH+1 edges after the edge accepting start.
REQ-018 busy SHALL be 1 exactly in ADD, 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in ADD and DONE; a, b, cin changes during ADD SHALL not affect the result.
REQ-020 sum and cout SHALL hold their last result from DONE until the next accepted start.
REQ-021 Back-to-back: start high in the IDLE cycle following DONE SHALL be accepted; minimum issue interval is WIDTH+2 cycles.
REQ-022 Boundary: all-ones + 1 SHALL wrap to sum=0, cout=1; WIDTH=1 SHALL behave as a registered full adder.

Reset
REQ-023 reset=1 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, sum=0, cout=0, counter and carry flop 0.
REQ-024 Reset asserted mid-ADD SHALL abort the addition; no done pulse SHALL follow after release.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: SHALL add port ovf  output  1  signed (two's-complement) overflow = carry into bit WIDTH-1 XOR cout, registered, valid and held like sum, reset to 0.
REQ-026 Macro SERIAL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-027 WIDTH=8: a=0x00, b=0x00, cin=0, start one cycle -> busy for 8 cycles, done 9 edges after start, sum=0x00, cout=0.
REQ-028 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x5A, b=0x33, cin=1 -> sum=0x8E, cout=0.
REQ-029 WIDTH=8 with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-030 Start pulsed again during ADD with different operands -> ignored; first result returned unchanged, single done pulse.
REQ-031 Reset asserted during 4th ADD cycle -> outputs 0 immediately, IDLE after release, no done pulse; a new start then completes normally.
REQ-032 WIDTH=1: all eight (a, b, cin) combinations -> sum/cout match full-adder truth table, done 2 edges after start.
